// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  // sll $0,$0,0 -- what a flushed stage register is loaded with
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Register 0 is hard-wired, so it never carries a real dependency.
  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic             used,
                                   input logic [REG_W-1:0] dst);
    return used && (src == dst) && (dst != '0);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational data-hazard detector for the ID-stage instruction.
// PIPE_CTRL_FWD_EN: forwarding present, only load-use hazards stall.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  output logic             stall
);

  logic ex_match;
  logic mem_match;
  logic load_use;

  assign ex_match  = reg_hit(id_rs, id_use_rs, ex_rd)  || reg_hit(id_rt, id_use_rt, ex_rd);
  assign mem_match = reg_hit(id_rs, id_use_rs, mem_rd) || reg_hit(id_rt, id_use_rt, mem_rd);
  assign load_use  = ex_memread && ex_match;

`ifdef PIPE_CTRL_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_regwrite, mem_regwrite, mem_match};
  assign stall      = load_use;
`else
  // WB producers are absent: the register file writes before it reads.
  assign stall = load_use || (ex_regwrite && ex_match) || (mem_regwrite && mem_match);
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with memory-wait timeout FSM.
// PIPE_CTRL_FWD_EN (see hazard_detect) selects forwarding-aware stalls.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_o
);

  localparam int unsigned WC_W = $clog2(WAIT_MAX + 1);

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            hz_stall;
  logic            mem_stall;
  logic            run_rules;
  logic            wait_rules;
  logic            pc_go, ifid_go, idex_go, exmem_go, memwb_go;
  logic            ifid_fl, idex_fl, memwb_bub;

  hazard_detect u_hazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .stall        (hz_stall)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    run_rules  = 1'b0;
    wait_rules = 1'b0;
    case (state)
      RUN:      begin run_rules = !mem_stall; wait_rules = mem_stall;  end
      MEM_WAIT: begin run_rules = mem_ready;  wait_rules = !mem_ready; end
      default:  ;
    endcase
  end

  // Pre-reset-mask controls; the stall counter follows these so reset never
  // sits in a synchronous data path.
  always_comb begin
    pc_go     = 1'b0;
    ifid_go   = 1'b0;
    idex_go   = 1'b0;
    exmem_go  = 1'b0;
    memwb_go  = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    memwb_bub = 1'b0;
    if (run_rules) begin
      pc_go    = 1'b1;
      ifid_go  = 1'b1;
      idex_go  = 1'b1;
      exmem_go = 1'b1;
      memwb_go = 1'b1;
      if (branch_taken) begin
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
      end else if (hz_stall) begin
        pc_go   = 1'b0;
        ifid_go = 1'b0;
        idex_fl = 1'b1;
      end
    end else if (wait_rules) begin
      memwb_go  = 1'b1;
      memwb_bub = 1'b1;
    end
  end

  assign pc_en         = rst_n && pc_go;
  assign if_id_en      = rst_n && ifid_go;
  assign id_ex_en      = rst_n && idex_go;
  assign ex_mem_en     = rst_n && exmem_go;
  assign mem_wb_en     = rst_n && memwb_go;
  assign if_id_flush   = rst_n && ifid_fl;
  assign id_ex_flush   = rst_n && idex_fl;
  assign mem_wb_bubble = rst_n && memwb_bub;
  assign state_o       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (!pc_go && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          // Completion is checked before the limit so a last-moment ready wins.
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WC_W'(WAIT_MAX)) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        ERR:     mem_err <= 1'b1;
        default: state   <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (WAIT_MAX=15, CNT_W=5).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite;
  logic       branch_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_err;
  logic [4:0] stall_cnt;
  logic [1:0] state_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pipe_ctrl #(.WAIT_MAX(15), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  wire [4:0] en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  wire [2:0] fl = {if_id_flush, id_ex_flush, mem_wb_bubble};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp_en, input logic [2:0] exp_fl);
    chk({tag, ".en"}, 32'(en), 32'(exp_en));
    chk({tag, ".fl"}, 32'(fl), 32'(exp_fl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = '0; mem_regwrite = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    #2;
    chk_ctl("reset", 5'b00000, 3'b000);
    chk("reset.state", 32'(state_o), 0);
    chk("reset.cnt", 32'(stall_cnt), 0);
    chk("reset.err", 32'(mem_err), 0);
    tick(); tick();
    chk("reset.hold", 32'(stall_cnt), 0);
    rst_n = 1'b1;
    #1;
    chk_ctl("idle", 5'b11111, 3'b000);

    // Load-use on rs
    id_rs = 5; id_use_rs = 1; ex_rd = 5; ex_memread = 1;
    #1;
    chk_ctl("loaduse", 5'b00111, 3'b010);
    tick();
    clear_in();
    #1;
    chk_ctl("loaduse.after", 5'b11111, 3'b000);
    chk("loaduse.cnt", 32'(stall_cnt), 1);

    // Register 0 never matches
    id_rs = 0; id_use_rs = 1; ex_rd = 0; ex_memread = 1; ex_regwrite = 1;
    #1;
    chk_ctl("reg0", 5'b11111, 3'b000);
    tick();
    chk("reg0.cnt", 32'(stall_cnt), 1);
    clear_in();

    // Branch overrides a simultaneous load-use stall
    id_rs = 5; id_use_rs = 1; ex_rd = 5; ex_memread = 1; branch_taken = 1;
    #1;
    chk_ctl("branch", 5'b11111, 3'b110);
    tick();
    chk("branch.cnt", 32'(stall_cnt), 1);
    clear_in();

    // Unused source register never stalls
    id_rt = 7; id_use_rt = 0; ex_rd = 7; ex_memread = 1;
    #1;
    chk_ctl("nouse", 5'b11111, 3'b000);
    clear_in();

    // Non-load producers: stall only without forwarding
    id_rt = 7; id_use_rt = 1; ex_rd = 7; ex_regwrite = 1;
    #1;
`ifdef PIPE_CTRL_FWD_EN
    chk_ctl("fwd.ex", 5'b11111, 3'b000);
`else
    chk_ctl("fwd.ex", 5'b00111, 3'b010);
`endif
    clear_in();
    id_rs = 9; id_use_rs = 1; mem_rd = 9; mem_regwrite = 1;
    #1;
`ifdef PIPE_CTRL_FWD_EN
    chk_ctl("fwd.mem", 5'b11111, 3'b000);
`else
    chk_ctl("fwd.mem", 5'b00111, 3'b010);
`endif
    clear_in();

    // Reset pulse before memory scenarios
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst2.cnt", 32'(stall_cnt), 0);
    rst_n = 1'b1;
    #1;

    // Memory wait, 3 low cycles; a pending branch is deferred
    mem_req = 1; branch_taken = 1;
    #1;
    chk_ctl("mw.c0", 5'b00001, 3'b001);
    tick();
    chk("mw.c1.state", 32'(state_o), 1);
    chk_ctl("mw.c1", 5'b00001, 3'b001);
    tick();
    chk_ctl("mw.c2", 5'b00001, 3'b001);
    tick();
    mem_ready = 1;
    #1;
    chk("mw.c3.state", 32'(state_o), 1);
    chk_ctl("mw.c3", 5'b11111, 3'b110);
    tick();
    clear_in();
    #1;
    chk("mw.done.state", 32'(state_o), 0);
    chk("mw.done.cnt", 32'(stall_cnt), 3);

    // Ready arriving exactly at the wait limit still completes
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mem_req = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("edge.state", 32'(state_o), 1);
    mem_ready = 1;
    #1;
    chk_ctl("edge.ready", 5'b11111, 3'b000);
    tick();
    chk("edge.back", 32'(state_o), 0);
    chk("edge.err", 32'(mem_err), 0);
    chk("edge.cnt", 32'(stall_cnt), 15);
    clear_in();

    // Timeout into ERR
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mem_req = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("to.pre", 32'(state_o), 1);
    tick();
    chk("to.state", 32'(state_o), 2);
    chk("to.err", 32'(mem_err), 1);
    chk_ctl("to.ctl", 5'b00000, 3'b000);
    chk("to.cnt", 32'(stall_cnt), 16);
    mem_ready = 1;
    tick();
    chk("to.sticky", 32'(state_o), 2);
    for (int i = 0; i < 20; i++) tick();
    chk("to.sat", 32'(stall_cnt), 31);

    // Asynchronous reset out of ERR
    rst_n = 1'b0;
    #1;
    chk("err.rst.state", 32'(state_o), 0);
    chk("err.rst.err", 32'(mem_err), 0);
    chk("err.rst.cnt", 32'(stall_cnt), 0);
    chk_ctl("err.rst", 5'b00000, 3'b000);
    clear_in();
    rst_n = 1'b1;
    #1;
    chk_ctl("err.rel", 5'b11111, 3'b000);
    tick();
    chk("err.rel.state", 32'(state_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of consecutive memory-wait cycles before an error is raised.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-003 SHALL have ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
- ex_rd  in  5  destination register in EX.
- ex_regwrite, ex_memread  in  1 each  EX instruction writes a register / is a load.
- mem_rd  in  5  destination register in MEM.
- mem_regwrite  in  1  MEM instruction writes a register.
- branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register enables.
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  load a NOP / force RegWrite=0 in that register.
- mem_err  out  1  sticky wait-timeout error.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- state_o  out  2  current FSM state.

Function
REQ-004 SHALL implement an FSM with states RUN=0, MEM_WAIT=1, ERR=2; enables and flushes SHALL be combinational from the state and the current inputs, giving zero-cycle latency.
REQ-005 In RUN with no hazard, all enables SHALL be 1 and all flushes 0.
REQ-006 Register matches SHALL ignore register 0; a WB-stage producer SHALL never cause a hazard, because the register file writes before it reads.
REQ-007 A load-use hazard SHALL cause a one-cycle stall: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
- Condition: ex_memread=1, and ex_rd matches a used id_rs or id_rt.
REQ-008 When branch_taken=1 in RUN, the block SHALL assert if_id_flush=1 and id_ex_flush=1 with pc_en=1, and branch_taken SHALL override any load-use stall in the same cycle.
REQ-009 When mem_req=1 and mem_ready=0 in RUN, the block SHALL:
- set pc_en, if_id_en, id_ex_en and ex_mem_en to 0;
- set mem_wb_en=1 and mem_wb_bubble=1;
- go to MEM_WAIT with the wait counter set to 1.
REQ-010 In MEM_WAIT, the outputs of REQ-009 SHALL hold and the wait counter SHALL increment each cycle.
REQ-011 On mem_ready=1 in MEM_WAIT, the block SHALL apply the RUN rules to that cycle's inputs and return to RUN.
REQ-012 Memory wait SHALL have the highest priority: branch_taken and hazards arriving during MEM_WAIT SHALL be deferred, not lost, because the stage registers are frozen.
REQ-013 If the wait counter reaches WAIT_MAX without mem_ready, the block SHALL enter ERR.
REQ-014 In ERR, all enables SHALL be 0 and mem_err=1, and the block SHALL leave ERR only by reset.
REQ-015 stall_cnt SHALL increment once per cycle in which pc_en=0, and SHALL saturate at all-ones without wrapping.
REQ-016 If mem_ready=1 in the same cycle that the wait counter reaches WAIT_MAX, the completion SHALL win and the block SHALL return to RUN.

Reset
REQ-017 While rst_n=0, the block SHALL hold state=RUN, the wait counter 0, stall_cnt 0 and mem_err 0, with all enables 0 and all flushes 0.
REQ-018 Reset asserted mid-MEM_WAIT or in ERR SHALL abort immediately and asynchronously; the first cycle after release SHALL evaluate as RUN.

Configuration
REQ-019 With PIPE_CTRL_FWD_EN defined, forwarding SHALL be assumed and only the load-use hazard of REQ-007 SHALL stall.
REQ-020 Without PIPE_CTRL_FWD_EN, a stall per REQ-007 SHALL also occur on any match with an EX or MEM producer that has regwrite=1.

Structure
REQ-021 A shared package pipe_pkg SHALL hold the state enum, the register-index width (5) and the NOP encoding.
REQ-022 The hazard comparison SHALL be one sub-module, hazard_detect, which is purely combinational and contains the PIPE_CTRL_FWD_EN selection.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_use_rs=1 -> one cycle with pc_en=0 and id_ex_flush=1, then all enables return to 1 and stall_cnt=1.
- Register 0: ex_memread=1, ex_rd=0, id_rs=0 -> no stall.
- Branch over stall: branch_taken=1 in the same cycle as the REQ-007 hazard -> if_id_flush=1, id_ex_flush=1, pc_en=1.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> 3 cycles in MEM_WAIT with mem_wb_bubble=1, then RUN; stall_cnt=3.
- Timeout: mem_ready held low -> ERR after WAIT_MAX=15 cycles with mem_err=1; a rst_n pulse mid-ERR clears the block to RUN with all counters 0.
- Forwarding on/off: ex_regwrite=1, ex_memread=0, ex_rd=7, id_rt=7, id_use_rt=1 -> no stall with PIPE_CTRL_FWD_EN defined, a one-cycle stall without it.
